// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600@60 timing constants and sync polarity for the VGA pipeline.
// Sync polarity follows VGA_TIMING_SYNC_NEG_EN (defined: active-low syncs).
package vga_pkg;

   localparam int CNT_W = 11;

   localparam int HOR_PIXELS     = 800;
   localparam int HOR_TOTAL_TIME = 1056;
   localparam int HOR_SYNC_START = 840;
   localparam int HOR_SYNC_TIME  = 128;

   localparam int VER_PIXELS     = 600;
   localparam int VER_TOTAL_TIME = 628;
   localparam int VER_SYNC_START = 601;
   localparam int VER_SYNC_TIME  = 4;

`ifdef VGA_TIMING_SYNC_NEG_EN
   localparam logic SYNC_ACT = 1'b0;
`else
   localparam logic SYNC_ACT = 1'b1;
`endif

endpackage

// File: rtl/itf_vga.sv
// rtl/itf_vga.sv - VGA pixel stream bundle passed between timing and draw stages.
interface itf_vga;

   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrap-at-TOTAL axis counter with registered blank/sync decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL       = HOR_TOTAL_TIME,
   parameter int BLANK_START = HOR_PIXELS,
   parameter int SYNC_START  = HOR_SYNC_START,
   parameter int SYNC_LEN    = HOR_SYNC_TIME
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_o,
   output logic             blank_o,
   output logic             sync_o
);

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] BLANK_LO = CNT_W'(BLANK_START);
   localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
   localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blank_q, blank_d;
   logic             sync_q, sync_d;
   logic             at_last;

   assign at_last = (cnt_q == LAST);

   // Decode the value the counter is about to take so flags line up with it.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
      end
      blank_d = (cnt_d >= BLANK_LO);
      sync_d  = ((cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI)) ? SYNC_ACT : ~SYNC_ACT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         blank_q <= 1'b0;
         sync_q  <= ~SYNC_ACT;
      end else begin
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign wrap_o  = at_last;
   assign blank_o = blank_q;
   assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing source with frame strobe and frame counter.
// Sync polarity selected by VGA_TIMING_SYNC_NEG_EN.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = HOR_PIXELS,
   parameter int H_FP        = HOR_SYNC_START - HOR_PIXELS,
   parameter int H_SYNC      = HOR_SYNC_TIME,
   parameter int H_BP        = HOR_TOTAL_TIME - HOR_SYNC_START - HOR_SYNC_TIME,
   parameter int V_ACTIVE    = VER_PIXELS,
   parameter int V_FP        = VER_SYNC_START - VER_PIXELS,
   parameter int V_SYNC      = VER_SYNC_TIME,
   parameter int V_BP        = VER_TOTAL_TIME - VER_SYNC_START - VER_SYNC_TIME,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   itf_vga.out                    out,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] hcount, vcount;
   logic             h_wrap, v_wrap;
   logic             hblnk, vblnk, hsync, vsync;

   vga_axis_counter #(
      .TOTAL       (H_TOTAL),
      .BLANK_START (H_ACTIVE),
      .SYNC_START  (H_ACTIVE + H_FP),
      .SYNC_LEN    (H_SYNC)
   ) u_hor (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (en),
      .cnt_o   (hcount),
      .wrap_o  (h_wrap),
      .blank_o (hblnk),
      .sync_o  (hsync)
   );

   vga_axis_counter #(
      .TOTAL       (V_TOTAL),
      .BLANK_START (V_ACTIVE),
      .SYNC_START  (V_ACTIVE + V_FP),
      .SYNC_LEN    (V_SYNC)
   ) u_ver (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (en & h_wrap),
      .cnt_o   (vcount),
      .wrap_o  (v_wrap),
      .blank_o (vblnk),
      .sync_o  (vsync)
   );

   logic                   frame_start_q, frame_start_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   // The strobe is recomputed every edge, so a disabled edge always clears it.
   always_comb begin
      frame_start_d = en & h_wrap & v_wrap;
      frame_cnt_d   = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign out.hcount  = hcount;
   assign out.vcount  = vcount;
   assign out.hblnk   = hblnk;
   assign out.vblnk   = vblnk;
   assign out.hsync   = hsync;
   assign out.vsync   = vsync;
   assign out.rgb     = 12'h000;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized scoreboard bench for vga_timing_gen on reduced timing.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
   localparam int FW = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int TOT = HT * VT;
`ifdef VGA_TIMING_SYNC_NEG_EN
   localparam bit NEG = 1'b1;
`else
   localparam bit NEG = 1'b0;
`endif

   typedef struct {
      int h; int v; bit hb; bit vb; bit hs; bit vs; bit fs; int fc;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          frame_start;
   logic [FW-1:0] frame_cnt;

   itf_vga vga_if ();

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .FRAME_CNT_W (FW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .out         (vga_if),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_chk = 0;
   int   n_err = 0;
   exp_t q[$];

   // Reference: a single linear pixel index over the frame.
   int m_t  = 0;
   int m_fc = 0;
   bit m_fs = 0;
   bit saw_fc_wrap = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.h  = m_t % HT;
      e.v  = m_t / HT;
      e.hb = (e.h >= HA);
      e.vb = (e.v >= VA);
      e.hs = ((e.h >= HA + HF) && (e.h < HA + HF + HS)) ^ NEG;
      e.vs = ((e.v >= VA + VF) && (e.v < VA + VF + VS)) ^ NEG;
      e.fs = m_fs;
      e.fc = m_fc;
      return e;
   endfunction

   task automatic step(input bit e, input bit r);
      @(negedge clk);
      rst_n = r;
      en    = e;
      if (!r) begin
         m_t = 0; m_fs = 0; m_fc = 0;
      end else if (e) begin
         m_fs = (m_t == TOT - 1);
         m_t  = (m_t + 1) % TOT;
         if (m_fs) m_fc = (m_fc + 1) % (1 << FW);
      end else begin
         m_fs = 0;
      end
      q.push_back(model_out());
   endtask

   initial begin : monitor
      exp_t e;
      int   prev_fc;
      prev_fc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("hcount", int'(vga_if.hcount), e.h);
            chk("vcount", int'(vga_if.vcount), e.v);
            chk("hblnk", int'(vga_if.hblnk), int'(e.hb));
            chk("vblnk", int'(vga_if.vblnk), int'(e.vb));
            chk("hsync", int'(vga_if.hsync), int'(e.hs));
            chk("vsync", int'(vga_if.vsync), int'(e.vs));
            chk("rgb", int'(vga_if.rgb), 0);
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("frame_cnt", int'(frame_cnt), e.fc);
            if (prev_fc == (1 << FW) - 1 && int'(frame_cnt) == 0) saw_fc_wrap = 1;
            prev_fc = int'(frame_cnt);
         end
      end
   end

   initial begin : stimulus
      exp_t e;
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) step(0, 0);
      repeat (2) step(0, 1);
      repeat (2 * TOT) step(1, 1);

      // Freeze mid-line.
      for (int i = 0; i < TOT && (m_t % HT) != 10; i++) step(1, 1);
      repeat (10) step(0, 1);
      repeat (5) step(1, 1);

      // Drop enable right after the frame wrap.
      for (int i = 0; i < TOT && m_t != TOT - 1; i++) step(1, 1);
      step(1, 1);
      repeat (3) step(0, 1);
      repeat (5) step(1, 1);

      repeat (3 * TOT) step(($urandom % 4) != 0, 1);

      // Asynchronous reset inside both sync regions.
      for (int i = 0; i < 2 * TOT; i++) begin
         e = model_out();
         if (e.h == HA + HF + 1 && e.v == VA + VF + 1) break;
         step(1, 1);
      end
      e = model_out();
      chk("reach_sync_region", e.h * 100 + e.v, (HA + HF + 1) * 100 + VA + VF + 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_hcount", int'(vga_if.hcount), 0);
      chk("arst_vcount", int'(vga_if.vcount), 0);
      chk("arst_hsync", int'(vga_if.hsync), int'(NEG));
      chk("arst_vsync", int'(vga_if.vsync), int'(NEG));
      chk("arst_hblnk", int'(vga_if.hblnk), 0);
      chk("arst_vblnk", int'(vga_if.vblnk), 0);
      chk("arst_frame_start", int'(frame_start), 0);
      chk("arst_frame_cnt", int'(frame_cnt), 0);
      step(1, 0);
      repeat (3) step(1, 1);

      // Enough whole frames to roll the frame counter over.
      repeat (((1 << FW) + 1) * TOT + 5) step(1, 1);

      @(posedge clk);
      #3;
      chk("queue_drained", q.size(), 0);
      chk("frame_cnt_wrapped", int'(saw_fc_wrap), 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
